interrupt_ack_sequencer: RTL
============================

# interrupt_ack_sequencer

Sequences the 8086-mode interrupt acknowledge cycle of the 8259A PIC. Sits between the Interrupt Request Register (masked pending bits in, serviced-level reset out) and the CPU-side control/data buffer. Owns the In-Service Register (ISR), resolves fixed priority under full nesting, drives INT, runs the two-pulse INTA handshake, and handles EOI / Auto-EOI.

## Interface
- No parameters; width fixed at 8 levels, priority fixed (IR0 highest, IR7 lowest).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- risedBits  in  8  masked pending requests from IRR.
- readPriorityAck  in  1  IRR acknowledge of readPriority.
- intaN  in  1  CPU INTA, active-low, already synchronized to clk.
- vectorBase  in  5  ICW2 bits T7..T3.
- autoEOI  in  1  ICW4 AEOI mode.
- eoiStrobe  in  1  one-cycle OCW2 EOI command.
- specificEoi  in  1  qualifies eoiStrobe: 1 = specific, 0 = non-specific.
- eoiLevel  in  3  level for specific EOI.
- INT  out  1  interrupt request to CPU.
- readPriority  out  1  freeze/read request to IRR.
- resetIRR  out  3  level being serviced, to IRR.
- resetIRRValid  out  1  one-cycle qualifier for resetIRR.
- ISR  out  8  In-Service Register.
- vectorOut  out  8  interrupt vector to data buffer.
- vectorOutEn  out  1  data buffer drive enable.

## Operation
- Candidate = lowest-index set bit of risedBits. Eligible when candidate exists and no ISR bit at index <= candidate is set.
- States: IDLE, REQ, ACK1, ACK2, DRIVE.
- IDLE: eligible -> INT=1, go REQ.
- REQ: on INTA falling edge (intaN prev 1, now 0): latch level L = candidate if eligible this cycle, else L=7 spurious; INT=0; go ACK1.
- Non-spurious ACK1 entry: ISR[L] set, resetIRR=L, resetIRRValid pulsed one cycle, readPriority asserted and held until readPriorityAck sampled 1.
- Spurious: ISR unchanged, no resetIRRValid, no readPriority.
- ACK1: wait for INTA rise, then go ACK2. ACK2: on second INTA fall, vectorOut={vectorBase,L}, vectorOutEn=1, go DRIVE.
- DRIVE: on intaN sampled 1, vectorOutEn=0; if autoEOI and non-spurious, clear ISR[L] same cycle; go IDLE.
- EOI (any state): non-specific clears lowest-index set ISR bit (none set -> no effect); specific clears ISR[eoiLevel].
- ISR update rule: ISR_next = (ISR & ~clear) | set; set wins on same bit.
- readPriority handshake independent of INTA progress; may still be high in ACK2/DRIVE.

## Timing
- Reset values: INT 0, readPriority 0, resetIRR 0, resetIRRValid 0, ISR 0x00, vectorOut 0x00, vectorOutEn 0, state IDLE.
- Eligible sampled cycle C -> INT high at C+1.
- First INTA fall sampled cycle N -> INT low, ISR[L], resetIRR/resetIRRValid, readPriority all valid at N+1.
- readPriorityAck sampled high cycle A -> readPriority low at A+1.
- Second INTA fall sampled cycle M -> vectorOut/vectorOutEn valid at M+1.
- INTA rise sampled cycle R in DRIVE -> vectorOutEn low and AEOI clear at R+1.
- EOI strobe cycle E -> ISR change at E+1.
- Request withdrawn in REQ: INT stays high until first INTA; spurious vector 7 issued.
- Higher-priority request arriving during ACK1..DRIVE: not taken until IDLE.
- rst_n low at any point: immediate return to reset values, sequence abandoned.

## Test plan
- risedBits=0x24, vectorBase=0x08, two INTA pulses -> INT rises, ISR=0x04, resetIRR=2 pulse, vectorOut=0x42.
- ISR=0x04 held, risedBits=0x10 -> INT stays 0; risedBits=0x01 -> INT=1, sequence yields ISR=0x05, vectorOut={base,000}.
- risedBits=0x08 then cleared before first INTA -> vectorOut={base,111}, ISR unchanged, no resetIRRValid.
- autoEOI=1, risedBits=0x80 -> ISR[7] set after first INTA, cleared one cycle after second INTA rise.
- ISR=0x0A, non-specific EOI -> ISR=0x08; specific EOI level 3 -> ISR=0x00.
- rst_n asserted in DRIVE -> vectorOutEn, INT, ISR all 0 immediately; next request sequences normally.

Source files
------------

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer
//   8086-mode interrupt acknowledge sequencer for an 8259A-style PIC.
//   Owns the In-Service Register, resolves fixed priority (IR0 highest) under
//   full nesting, raises INT, runs the two-pulse INTA handshake and handles
//   specific / non-specific EOI and Auto-EOI.
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   risedBits       in   masked pending requests from the IRR
//   readPriorityAck in   IRR acknowledge of readPriority
//   intaN           in   CPU INTA (active low, already synchronized)
//   vectorBase      in   ICW2 T7..T3
//   autoEOI         in   ICW4 AEOI mode
//   eoiStrobe       in   one-cycle EOI command
//   specificEoi     in   1 = specific EOI, 0 = non-specific
//   eoiLevel        in   level for specific EOI
//   INT             out  interrupt request to the CPU
//   readPriority    out  freeze/read request to the IRR
//   resetIRR        out  level being serviced
//   resetIRRValid   out  one-cycle qualifier for resetIRR
//   ISR             out  In-Service Register
//   vectorOut       out  interrupt vector to the data buffer
//   vectorOutEn     out  data buffer drive enable

module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] risedBits,
    input  logic       readPriorityAck,
    input  logic       intaN,
    input  logic [4:0] vectorBase,
    input  logic       autoEOI,
    input  logic       eoiStrobe,
    input  logic       specificEoi,
    input  logic [2:0] eoiLevel,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic       resetIRRValid,
    output logic [7:0] ISR,
    output logic [7:0] vectorOut,
    output logic       vectorOutEn
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck1,
        StAck2,
        StDrive
    } state_e;

    state_e     r_state;
    logic       r_inta_prev;
    logic [2:0] r_level;
    logic       r_spurious;
    logic       r_int;
    logic       r_read_priority;
    logic [2:0] r_reset_irr;
    logic       r_reset_irr_valid;
    logic [7:0] r_isr;
    logic [7:0] r_vector;
    logic       r_vector_en;

    logic       w_cand_valid;
    logic [2:0] w_cand;
    logic [7:0] w_le_mask;
    logic       w_eligible;
    logic       w_inta_fall;
    logic       w_inta_rise;
    logic [7:0] w_isr_lowest;
    logic [7:0] w_set;
    logic [7:0] w_clear;

    // Lowest-index pending request and the mask of ISR levels that block it
    // (any in-service level at equal or higher priority).
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (risedBits[i]) begin
                w_cand_valid = 1'b1;
                w_cand       = 3'(i);
            end
        end
        w_le_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_le_mask[i] = (i <= int'(w_cand));
        end
    end

    assign w_eligible  = w_cand_valid && ((r_isr & w_le_mask) == 8'h00);
    assign w_inta_fall = r_inta_prev & ~intaN;
    assign w_inta_rise = ~r_inta_prev & intaN;

    // One-hot of the highest-priority in-service level (non-specific EOI).
    always_comb begin
        w_isr_lowest = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (r_isr[i]) begin
                w_isr_lowest    = 8'h00;
                w_isr_lowest[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_set = 8'h00;
        if (r_state == StReq && w_inta_fall && w_eligible) begin
            w_set = 8'h01 << w_cand;
        end

        w_clear = 8'h00;
        if (eoiStrobe) begin
            w_clear = specificEoi ? (8'h01 << eoiLevel) : w_isr_lowest;
        end
        if (r_state == StDrive && intaN && autoEOI && !r_spurious) begin
            w_clear = w_clear | (8'h01 << r_level);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_inta_prev       <= 1'b1;
            r_level           <= 3'd0;
            r_spurious        <= 1'b0;
            r_int             <= 1'b0;
            r_read_priority   <= 1'b0;
            r_reset_irr       <= 3'd0;
            r_reset_irr_valid <= 1'b0;
            r_isr             <= 8'h00;
            r_vector          <= 8'h00;
            r_vector_en       <= 1'b0;
        end else begin
            r_inta_prev       <= intaN;
            r_reset_irr_valid <= 1'b0;
            // Set wins over clear on the same bit.
            r_isr             <= (r_isr & ~w_clear) | w_set;

            // The IRR handshake runs independently of INTA progress.
            if (r_read_priority && readPriorityAck) begin
                r_read_priority <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_eligible) begin
                        r_int   <= 1'b1;
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    // INT stays high until the first INTA even if the request
                    // is withdrawn; a withdrawn request yields spurious IR7.
                    if (w_inta_fall) begin
                        r_int   <= 1'b0;
                        r_state <= StAck1;
                        if (w_eligible) begin
                            r_level           <= w_cand;
                            r_spurious        <= 1'b0;
                            r_reset_irr       <= w_cand;
                            r_reset_irr_valid <= 1'b1;
                            r_read_priority   <= 1'b1;
                        end else begin
                            r_level    <= 3'd7;
                            r_spurious <= 1'b1;
                        end
                    end
                end
                StAck1: begin
                    if (w_inta_rise) begin
                        r_state <= StAck2;
                    end
                end
                StAck2: begin
                    if (w_inta_fall) begin
                        r_vector    <= {vectorBase, r_level};
                        r_vector_en <= 1'b1;
                        r_state     <= StDrive;
                    end
                end
                StDrive: begin
                    if (intaN) begin
                        r_vector_en <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign INT           = r_int;
    assign readPriority  = r_read_priority;
    assign resetIRR      = r_reset_irr;
    assign resetIRRValid = r_reset_irr_valid;
    assign ISR           = r_isr;
    assign vectorOut     = r_vector;
    assign vectorOutEn   = r_vector_en;

endmodule
